// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared constants and state encoding for the truth-table sweep controller
package hd_pkg;

    localparam int HD_N_IN = 3;
    localparam logic [7:0] HD_EXP_MASK = 8'hA2;

    typedef logic [1:0] hd_state_t;

    localparam hd_state_t ST_IDLE   = 2'd0;
    localparam hd_state_t ST_APPLY  = 2'd1;
    localparam hd_state_t ST_SAMPLE = 2'd2;
    localparam hd_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/hd_sweep_ctrl_if.sv
// rtl/hd_sweep_ctrl_if.sv - vector/response link between the sweep controller and the unit under test
interface hd_sweep_ctrl_if #(
    parameter int N_IN = 3
);
    logic [N_IN-1:0] dut_vec;
    logic            dut_y;

    modport master (output dut_vec, input dut_y);
    modport slave  (input dut_vec, output dut_y);
endinterface

// File: rtl/hd_vec_counter.sv
// rtl/hd_vec_counter.sv - vector index and per-vector settle counter
module hd_vec_counter #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            run,
    input  logic            hold,
    input  logic            advance,
    output logic [N_IN-1:0] idx,
    output logic            settle_done,
    output logic            last_vec
);

    logic [3:0] cnt;

    assign settle_done = (cnt == 4'(SETTLE - 1));
    assign last_vec    = (idx == {N_IN{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= '0;
            cnt <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
            cnt <= '0;
        end else if (run && !hold && !settle_done) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/hd_sweep_ctrl.sv
// rtl/hd_sweep_ctrl.sv - exhaustive input sweep of a combinational unit with truth-table compare
module hd_sweep_ctrl
    import hd_pkg::*;
#(
    parameter int                 N_IN     = HD_N_IN,
    parameter int                 SETTLE   = 1,
    parameter logic [2**N_IN-1:0] EXP_MASK = HD_EXP_MASK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    hd_sweep_ctrl_if.master      dut_if,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      err_idx
);

    hd_state_t       state;
    logic [N_IN-1:0] idx;
    logic            settle_done;
    logic            last_vec;
    logic            clear;
    logic            advance;
    logic            mismatch;

    assign clear    = (state == ST_IDLE) && start;
    assign advance  = (state == ST_SAMPLE) && !hold && !last_vec;
    assign mismatch = (dut_if.dut_y != EXP_MASK[idx]);

    assign busy           = (state == ST_APPLY) || (state == ST_SAMPLE);
    assign done           = (state == ST_DONE);
    assign dut_if.dut_vec = idx;

    hd_vec_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vec_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .run         (state == ST_APPLY),
        .hold        (hold),
        .advance     (advance),
        .idx         (idx),
        .settle_done (settle_done),
        .last_vec    (last_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pass    <= 1'b0;
            tt      <= '0;
            err_cnt <= '0;
            err_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_APPLY;
                        pass    <= 1'b0;
                        tt      <= '0;
                        err_cnt <= '0;
                        err_idx <= '0;
                    end
                end
                ST_APPLY: begin
                    if (!hold && settle_done) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (!hold) begin
                        tt[idx] <= dut_if.dut_y;
                        if (mismatch) begin
                            err_cnt <= err_cnt + (N_IN+1)'(1);
                            if (err_cnt == '0) err_idx <= idx;
                        end
                        // pass folds in the final vector so it is already valid during DONE
                        if (last_vec) begin
                            state <= ST_DONE;
                            pass  <= !mismatch && (err_cnt == '0);
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_sweep_ctrl.sv
// tb/tb_hd_sweep_ctrl.sv - self-checking bench for hd_sweep_ctrl
module tb_hd_sweep_ctrl;
    import hd_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic       busy, done, pass;
    logic [7:0] tt;
    logic [3:0] err_cnt;
    logic [2:0] err_idx;

    int         mode;
    logic [7:0] rtab;
    int         checks = 0;
    int         passed = 0;

    hd_sweep_ctrl_if #(.N_IN(3)) bus ();

    hd_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXP_MASK(HD_EXP_MASK)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hold    (hold),
        .dut_if  (bus),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .tt      (tt),
        .err_cnt (err_cnt),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    function automatic logic ref_y(int m, logic [2:0] v, logic [7:0] tab);
        logic f;
        f = (~v[1] & v[0]) | (v[2] & v[0]);
        case (m)
            0:       return f;
            1:       return 1'b0;
            2:       return ~f;
            default: return tab[v];
        endcase
    endfunction

    always_comb bus.dut_y = ref_y(mode, bus.dut_vec, rtab);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int hmode, input bit poke_start);
        int         n, holds, e_err, e_idx;
        logic [7:0] e_tt;
        e_tt = '0;
        for (int v = 0; v < 8; v++) e_tt[v] = ref_y(mode, 3'(v), rtab);
        e_err = 0;
        e_idx = 0;
        for (int v = 0; v < 8; v++) begin
            if (e_tt[v] != HD_EXP_MASK[v]) begin
                if (e_err == 0) e_idx = v;
                e_err++;
            end
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        holds = 0;
        chk("first_busy", busy, 1);
        chk("first_vec", bus.dut_vec, 0);
        while (!done && n < 200) begin
            case (hmode)
                0:       hold = 1'b0;
                1:       hold = (n >= 7 && n <= 11) || n == 13;
                default: hold = ($urandom_range(3) == 0);
            endcase
            holds += int'(hold);
            start = poke_start && (n == 5);
            tick();
            n++;
        end
        hold  = 1'b0;
        start = 1'b0;
        chk("done_cycle", n, 17 + holds);
        chk("tt", tt, e_tt);
        chk("err_cnt", err_cnt, e_err);
        chk("err_idx", err_idx, e_idx);
        chk("pass", pass, e_err == 0);

        start = poke_start;
        tick();
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_vec", bus.dut_vec, 3'b111);
        repeat (3) tick();
        chk("no_restart", {busy, done}, 0);
        chk("tt_stable", tt, e_tt);
        chk("err_cnt_stable", err_cnt, e_err);
        chk("pass_stable", pass, e_err == 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        mode  = 0;
        rtab  = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tt", tt, 0);
        chk("rst_err", {err_cnt, err_idx}, 0);
        chk("rst_vec", bus.dut_vec, 0);
        rst = 1'b0;
        tick();

        mode = 0; sweep(0, 1'b1);
        mode = 1; sweep(0, 1'b0);
        mode = 2; sweep(0, 1'b0);
        mode = 0; sweep(1, 1'b0);

        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_vec", bus.dut_vec, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_tt", tt, 0);
        chk("abort_err", {err_cnt, err_idx}, 0);
        chk("abort_vec", bus.dut_vec, 0);
        tick();
        sweep(0, 1'b0);

        mode = 3;
        for (int r = 0; r < 4; r++) begin
            rtab = 8'($urandom);
            sweep(2, r[0]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
